// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
package fetch_pkg;

    localparam int unsigned FETCH_WORD_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue with wrapping pointers, occupancy count and flush.
// A push into a full queue is accepted only when a pop frees an entry on the same edge.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  fetch_entry_t         push_entry,
    input  logic                 pop,
    output logic                 head_valid,
    output fetch_entry_t         head_entry,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: data storage has no reset; the occupancy count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Empty head reads as zero so uninitialised storage never reaches the consumer.
    assign head_valid = (count_q != '0);
    assign head_entry = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: four byte reads per word, assembled little-endian into a queue.
// Define FETCH_ALIGN_CHECK_EN to halt on a misaligned redirect target.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned
);

    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [1:0]  LAST_BYTE = 2'(FETCH_WORD_BYTES - 1);

    fetch_state_e     state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [1:0]       req_k_q, req_k_d;
    logic [31:0]      req_base_q, req_base_d;
    logic             rsp_pending_q, rsp_pending_d;
    logic [1:0]       rsp_k_q, rsp_k_d;
    logic [31:0]      rsp_base_q, rsp_base_d;
    logic [23:0]      asm_q, asm_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             misaligned_q, misaligned_d;

    logic             redirect_take, redirect_bad;
    logic             q_push, q_pop, q_valid, has_space, issue;
    logic [1:0]       issue_k;
    logic [31:0]      issue_base;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   words_used;
    fetch_entry_t     push_entry, head_entry;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_bad = 1'b0;
`endif

    // A push moves a word from in-flight to queued, so it never changes the total held.
    always_comb begin
        redirect_take = redirect_valid && (state_q != HALT);
        q_pop         = q_valid && instr_ready && !redirect_take;
        q_push        = rsp_pending_q && (rsp_k_q == LAST_BYTE) && !redirect_take;
        push_entry    = '{pc: rsp_base_q, word: {mem_rdata, asm_q}};
        words_used    = (CNT_W+1)'(q_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(q_pop);
        has_space     = words_used < (CNT_W+1)'(DEPTH);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        req_k_d       = req_k_q;
        req_base_d    = req_base_q;
        rsp_pending_d = mem_req_q;
        rsp_k_d       = req_k_q;
        rsp_base_d    = req_base_q;
        asm_d         = asm_q;
        misaligned_d  = misaligned_q;
        inflight_d    = q_push ? inflight_q - CNT_W'(1) : inflight_q;
        issue         = 1'b0;
        issue_k       = 2'd0;
        issue_base    = pc_q;

        if (rsp_pending_q && (rsp_k_q != LAST_BYTE)) asm_d[{rsp_k_q, 3'b000} +: 8] = mem_rdata;

        if (state_q == HALT) begin
            rsp_pending_d = 1'b0;
        end else if (redirect_take) begin
            // The byte returning next cycle belongs to the abandoned stream.
            rsp_pending_d = 1'b0;
            cnt_d         = 2'd0;
            inflight_d    = '0;
            if (redirect_bad) begin
                state_d      = HALT;
                misaligned_d = 1'b1;
            end else begin
                state_d    = FETCH;
                pc_d       = redirect_pc;
                issue      = 1'b1;
                issue_base = redirect_pc;
                cnt_d      = 2'd1;
                inflight_d = CNT_W'(1);
            end
        end else if ((state_q == FETCH) && (cnt_q != 2'd0)) begin
            issue   = 1'b1;
            issue_k = cnt_q;
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == LAST_BYTE) pc_d = pc_q + 32'(FETCH_WORD_BYTES);
        end else if (has_space) begin
            state_d    = FETCH;
            issue      = 1'b1;
            cnt_d      = 2'd1;
            inflight_d = inflight_d + CNT_W'(1);
        end else begin
            state_d = STALL;
        end

        if (issue) begin
            mem_req_d  = 1'b1;
            mem_addr_d = issue_base + {30'd0, issue_k};
            req_k_d    = issue_k;
            req_base_d = issue_base;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FETCH;
            cnt_q         <= 2'd0;
            pc_q          <= RESET_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            req_k_q       <= 2'd0;
            req_base_q    <= '0;
            rsp_pending_q <= 1'b0;
            rsp_k_q       <= 2'd0;
            rsp_base_q    <= '0;
            asm_q         <= '0;
            inflight_q    <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            req_k_q       <= req_k_d;
            req_base_q    <= req_base_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_k_q       <= rsp_k_d;
            rsp_base_q    <= rsp_base_d;
            asm_q         <= asm_d;
            inflight_q    <= inflight_d;
            misaligned_q  <= misaligned_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_take),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .head_valid (q_valid),
        .head_entry (head_entry),
        .count      (q_count)
    );

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = q_valid;
    assign instr       = head_entry.word;
    assign instr_pc    = head_entry.pc;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed words pushed as expectations, monitor compares pops.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, instr_valid, instr_ready, misaligned, redirect_valid;
    logic [31:0] mem_addr, redirect_pc, instr, instr_pc;
    logic [7:0]  mem_rdata;

    logic        hi_mem_req, hi_instr_valid, hi_misaligned;
    logic        hi_ready = 1'b1;
    logic        hi_redirect_valid = 1'b0;
    logic [31:0] hi_redirect_pc = 32'h0;
    logic [31:0] hi_mem_addr, hi_instr, hi_instr_pc;
    logic [7:0]  hi_mem_rdata;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] hi_log[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_pc = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .misaligned     (misaligned)
    );

    fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (hi_mem_req),
        .mem_addr       (hi_mem_addr),
        .mem_rdata      (hi_mem_rdata),
        .redirect_valid (hi_redirect_valid),
        .redirect_pc    (hi_redirect_pc),
        .instr_valid    (hi_instr_valid),
        .instr_ready    (hi_ready),
        .instr          (hi_instr),
        .instr_pc       (hi_instr_pc),
        .misaligned     (hi_misaligned)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] boot [4];
        boot = '{8'h13, 8'h05, 8'h50, 8'h00};
        if (a < 32'd4) return boot[a[1:0]];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory answers exactly one cycle after each request.
    always @(posedge clk) begin
        mem_rdata    <= mem_req ? mem_byte(mem_addr) : 8'h00;
        hi_mem_rdata <= hi_mem_req ? mem_byte(hi_mem_addr) : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_req) addr_log.push_back(mem_addr);
        if (hi_mem_req) hi_log.push_back(hi_mem_addr);
        if (hold_prev && instr_valid) begin
            check("hold_instr", instr, prev_instr);
            check("hold_pc", instr_pc, prev_pc);
        end
        if (rst && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: popped pc %08h word %08h, expected none", instr_pc, instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_word", instr, e.word);
            end
        end
        hold_prev  = rst && instr_valid && !instr_ready && !redirect_valid;
        prev_instr = instr;
        prev_pc    = instr_pc;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc   = pc;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic pop_one(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (instr_valid) seen = 1'b1;
            else step(1);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: instr_valid never rose, got 0 within 40 cycles, expected 1", name);
        end else begin
            instr_ready = 1'b1;
            step(1);
            instr_ready = 1'b0;
        end
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (mem_req && mem_addr == a) seen = 1'b1;
            else step(1);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1 rst = 1'b0;
        step(3);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_misaligned", 32'(misaligned), 32'd0);

        // First word: requests in cycles 0-3, valid in cycle 5; queue fills and fetch stalls.
        rst = 1'b1;
        addr_log.delete();
        hi_log.delete();
        step(5);
        check("c4_instr_valid", 32'(instr_valid), 32'd0);
        step(1);
        check("c5_instr_valid", 32'(instr_valid), 32'd1);
        check("c5_instr", instr, 32'h0050_0513);
        check("c5_instr_pc", instr_pc, 32'h0);
        check("hi_c5_pc", hi_instr_pc, 32'hFFFF_FFFC);
        check("hi_c5_word", hi_instr, 32'h5A5B_5859);
        step(4);
        check("hi_c9_valid", 32'(hi_instr_valid), 32'd1);
        check("hi_c9_pc", hi_instr_pc, 32'h0);
        check("hi_c9_word", hi_instr, 32'h0050_0513);
        step(20);
        check("stall_req_count", 32'(addr_log.size()), 32'd8);
        check("stall_mem_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("req_addr_%0d", i), addr_log[i], 32'(i));
            check($sformatf("hi_req_addr_%0d", i), hi_log[i], 32'hFFFF_FFFC + 32'(i));
        end

        // Drain two words, fetch resumes at 8; redirect while byte 2 of that word is out.
        addr_log.delete();
        push_exp(32'h0, 32'h0050_0513);
        push_exp(32'h4, 32'h5D5C_5F5E);
        pop_one("pop_w0");
        pop_one("pop_w4");
        wait_addr("found_byte_0xA", 32'hA);
        check("resume_addr", addr_log[0], 32'h8);
        redirect_to(32'h40);
        check("redir_instr_valid", 32'(instr_valid), 32'd0);
        check("redir_mem_req", 32'(mem_req), 32'd1);
        check("redir_mem_addr", mem_addr, 32'h40);
        push_exp(32'h40, 32'h1918_1B1A);
        pop_one("pop_w40");

        // Reset asserted with byte 1 of a word outstanding.
        wait_addr("found_byte_0x49", 32'h49);
        rst = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_instr_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_instr_pc", instr_pc, 32'h0);
        check("midrst_misaligned", 32'(misaligned), 32'd0);
        step(2);
        rst = 1'b1;
        step(1);
        check("post_rst_mem_req", 32'(mem_req), 32'd1);
        check("post_rst_mem_addr", mem_addr, 32'h0);
        push_exp(32'h0, 32'h0050_0513);
        pop_one("pop_after_rst");

        // Misaligned redirect target.
        redirect_to(32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_instr_valid", 32'(instr_valid), 32'd0);
        check("mis_mem_req", 32'(mem_req), 32'd0);
        addr_log.delete();
        step(20);
        check("mis_no_requests", 32'(addr_log.size()), 32'd0);
        check("mis_sticky", 32'(misaligned), 32'd1);
        check("mis_still_empty", 32'(instr_valid), 32'd0);
`else
        check("mis_flag", 32'(misaligned), 32'd0);
        check("mis_mem_addr", mem_addr, 32'h42);
        push_exp(32'h42, 32'h1F1E_1918);
        pop_one("pop_w42");
`endif

        step(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
